// File: rtl/fhn_neuron_array.sv
// rtl/fhn_neuron_array.sv - N time-multiplexed FitzHugh-Nagumo neurons on one forward-Euler datapath
// Optional macro FHN_NOISE_EN adds a 16-bit Fibonacci LFSR noise term to the stimulus.
module fhn_neuron_array #(
    parameter int          N           = 4,
    parameter int          W           = 16,
    parameter int          FRAC        = 12,
    parameter int          AW          = 2,
    parameter int          DT_SHIFT    = 6,
    parameter int          A           = 2867,
    parameter int          B           = 3277,
    parameter int          EPS         = 328,
    parameter int          V_REST      = -4915,
    parameter int          W_REST      = -2560,
    parameter int          V_TH        = 4096,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          NOISE_SHIFT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 step_start,
    input  logic                 i_we,
    input  logic [AW-1:0]        i_addr,
    input  logic signed [W-1:0]  i_data,
    input  logic [AW-1:0]        rd_addr,
    output logic signed [W-1:0]  v_rd,
    output logic signed [W-1:0]  w_rd,
    output logic                 busy,
    output logic                 done,
    output logic                 spike_valid,
    output logic [AW-1:0]        spike_id
);

    localparam int IW = W + 8;
    localparam int PW = 2 * IW;

    localparam logic signed [IW-1:0] K_THIRD = IW'(1365);
    localparam logic signed [IW-1:0] A_E     = IW'(A);
    localparam logic signed [IW-1:0] B_E     = IW'(B);
    localparam logic signed [IW-1:0] EPS_E   = IW'(EPS);
    localparam logic signed [IW-1:0] SAT_MAX = IW'(2 ** (W - 1) - 1);
    localparam logic signed [IW-1:0] SAT_MIN = IW'(-(2 ** (W - 1)));
    localparam logic signed [W-1:0]  VREST_W = W'(V_REST);
    localparam logic signed [W-1:0]  WREST_W = W'(W_REST);
    localparam logic signed [W-1:0]  VTH_W   = W'(V_TH);
    localparam logic [AW-1:0]        LAST    = AW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CUBE1,
        S_CUBE2,
        S_UPDATE,
        S_WRITE
    } state_t;

    state_t state, state_n;

    logic [AW-1:0]        idx;
    logic signed [W-1:0]  v_mem [N];
    logic signed [W-1:0]  w_mem [N];
    logic signed [W-1:0]  i_mem [N];

    logic signed [W-1:0]  v_l, w_l, i_l;
    logic signed [IW-1:0] p_r, c_r;
    logic signed [W-1:0]  vn_r, wn_r;

    logic signed [IW-1:0] v_e, w_e, i_e, i_eff;
    logic signed [IW-1:0] p_n, c_n, cterm, bterm, dv, dw, vsum, wsum;
    logic signed [W-1:0]  vn_sat, wn_sat;

`ifdef FHN_NOISE_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= LFSR_SEED;
        end else if (state == S_FETCH) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (step_start) state_n = S_FETCH;
            S_FETCH:  state_n = S_CUBE1;
            S_CUBE1:  state_n = S_CUBE2;
            S_CUBE2:  state_n = S_UPDATE;
            S_UPDATE: state_n = S_WRITE;
            S_WRITE:  state_n = (idx == LAST) ? S_IDLE : S_FETCH;
            default:  state_n = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

    // Every intermediate is W+8 bits; products are formed wide, shifted, then truncated.
    always_comb begin
        v_e    = IW'(v_l);
        w_e    = IW'(w_l);
        i_e    = IW'(i_l);
`ifdef FHN_NOISE_EN
        i_eff  = i_e + (IW'($signed(lfsr)) >>> NOISE_SHIFT);
`else
        i_eff  = i_e;
`endif
        p_n    = IW'((PW'(v_e) * PW'(v_e)) >>> FRAC);
        c_n    = IW'((PW'(p_r) * PW'(v_e)) >>> FRAC);
        cterm  = IW'((PW'(c_r) * PW'(K_THIRD)) >>> FRAC);
        bterm  = IW'((PW'(B_E) * PW'(w_e)) >>> FRAC);
        dv     = v_e - cterm - w_e + i_eff;
        dw     = IW'((PW'(EPS_E) * PW'(v_e + A_E - bterm)) >>> FRAC);
        vsum   = v_e + (dv >>> DT_SHIFT);
        wsum   = w_e + (dw >>> DT_SHIFT);
        vn_sat = (vsum > SAT_MAX) ? SAT_MAX[W-1:0] :
                 (vsum < SAT_MIN) ? SAT_MIN[W-1:0] : vsum[W-1:0];
        wn_sat = (wsum > SAT_MAX) ? SAT_MAX[W-1:0] :
                 (wsum < SAT_MIN) ? SAT_MIN[W-1:0] : wsum[W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx         <= '0;
            v_l         <= '0;
            w_l         <= '0;
            i_l         <= '0;
            p_r         <= '0;
            c_r         <= '0;
            vn_r        <= '0;
            wn_r        <= '0;
            done        <= 1'b0;
            spike_valid <= 1'b0;
            spike_id    <= '0;
        end else begin
            done        <= (state == S_WRITE) && (idx == LAST);
            spike_valid <= 1'b0;
            spike_id    <= '0;
            case (state)
                S_IDLE:  if (step_start) idx <= '0;
                S_FETCH: begin
                    v_l <= v_mem[idx];
                    w_l <= w_mem[idx];
                    i_l <= i_mem[idx];
                end
                S_CUBE1: p_r <= p_n;
                S_CUBE2: c_r <= c_n;
                S_UPDATE: begin
                    vn_r <= vn_sat;
                    wn_r <= wn_sat;
                    // Registered here so the event is visible during the WRITE cycle.
                    if ((v_l < VTH_W) && (vn_sat >= VTH_W)) begin
                        spike_valid <= 1'b1;
                        spike_id    <= idx;
                    end
                end
                S_WRITE: if (idx != LAST) idx <= idx + AW'(1);
                default: ;
            endcase
        end
    end

    // A stimulus write colliding with FETCH of the same index is seen only by the next step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                v_mem[k] <= VREST_W;
                w_mem[k] <= WREST_W;
                i_mem[k] <= '0;
            end
        end else begin
            if (state == S_WRITE) begin
                v_mem[idx] <= vn_r;
                w_mem[idx] <= wn_r;
            end
            if (i_we && (int'(i_addr) < N)) begin
                i_mem[i_addr] <= i_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_rd <= VREST_W;
            w_rd <= WREST_W;
        end else if (int'(rd_addr) < N) begin
            v_rd <= v_mem[rd_addr];
            w_rd <= w_mem[rd_addr];
        end else begin
            v_rd <= VREST_W;
            w_rd <= WREST_W;
        end
    end

endmodule

// File: doc/fhn_neuron_array.md
Name: fhn_neuron_array

Overview:
Parametrised successor to the single FitzHugh-Nagumo `core`. It holds N neuron states and time-multiplexes them through one shared forward-Euler datapath in signed fixed point. Each step is started by a pulse; the block emits per-neuron spike events and gives registered readout of v and w. It sits between the stimulus/controller logic and spike routing.

Parameters:
N, 4, number of neurons; indices 0..N-1 (N >= 1).
W, 16, state, stimulus and constant width, signed.
FRAC, 12, fractional bits (Q(W-FRAC).FRAC).
AW, 2, address width; must satisfy 2^AW >= N.
DT_SHIFT, 6, Euler step dt = 2^-DT_SHIFT.
A, 2867, FHN a (0.7).
B, 3277, FHN b (0.8).
EPS, 328, FHN epsilon (0.08).
V_REST, -4915, reset value of every v (-1.2).
W_REST, -2560, reset value of every w (-0.625).
V_TH, 4096, spike threshold (1.0).
LFSR_SEED, 16'hACE1, noise LFSR seed; used only with FHN_NOISE_EN.
NOISE_SHIFT, 4, noise attenuation; used only with FHN_NOISE_EN.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
step_start  in  1  one-cycle request to update all N neurons.
i_we  in  1  stimulus write enable.
i_addr  in  AW  stimulus write index.
i_data  in  W  signed stimulus value.
rd_addr  in  AW  readout index.
v_rd  out  W  v[rd_addr], 1-cycle latency.
w_rd  out  W  w[rd_addr], 1-cycle latency.
busy  out  1  high while a step is in progress.
done  out  1  one-cycle pulse when a step completes.
spike_valid  out  1  one-cycle spike event.
spike_id  out  AW  index of the neuron that spiked.

Behaviour:
- Reset (rst=0, async): all v=V_REST, all w=W_REST, all stimulus=0, FSM=IDLE. busy, done, spike_valid and spike_id are 0. v_rd=V_REST and w_rd=W_REST. An in-flight step is abandoned with no done pulse.
- FSM states: IDLE -> FETCH -> CUBE1 -> CUBE2 -> UPDATE -> WRITE. From WRITE: go to FETCH for idx+1, or to IDLE when idx=N-1.
- IDLE: step_start=1 sets idx=0, busy=1, next state FETCH. step_start while busy is ignored and not queued.
- FETCH: latch v, w and I for neuron idx.
- CUBE1: p = (v*v)>>>FRAC.
- CUBE2: c = (p*v)>>>FRAC.
- UPDATE:
  - dv = v - ((c*1365)>>>FRAC) - w + I
  - dw = (EPS*(v + A - ((B*w)>>>FRAC)))>>>FRAC
  - vn = v + (dv>>>DT_SHIFT)
  - wn = w + (dw>>>DT_SHIFT)
  - Intermediates are W+8 bits. vn and wn saturate to [-2^(W-1), 2^(W-1)-1] and never wrap.
- WRITE: store vn and wn.
  - If v < V_TH and vn >= V_TH: spike_valid=1 and spike_id=idx in this cycle.
  - When idx=N-1: done=1 in the following cycle, and busy falls in that same cycle.
- Latency: 5 cycles per neuron. If step_start is sampled at edge 0, done is high in the cycle after edge 5N. For N=4, done is high during cycle 21.
- Stimulus writes are accepted at any time, including when busy.
  - A write lands before the FETCH of that neuron if it arrives earlier.
  - If a write and a FETCH hit the same index in the same cycle, FETCH sees the old value.
  - Last write wins.
- Readout: rd_addr is registered. v_rd/w_rd show stored state, so a neuron's value changes only at its WRITE. Indices >= N read V_REST/W_REST.
- Stimulus writes with i_addr >= N are ignored.

Optional Feature:
FHN_NOISE_EN: compiles in a 16-bit Fibonacci LFSR (taps 16,14,13,11) seeded with LFSR_SEED.
- It advances once per FETCH.
- In UPDATE, I is replaced by I + (sext(lfsr) >>> NOISE_SHIFT).
- Reset reloads LFSR_SEED.
- Without the macro: no LFSR logic; I is used unmodified and the results are bit-exact with the noiseless equations.

Test Plan:
1. Reset: hold rst=0 for 10 cycles, release, read all indices -> v_rd=-4915, w_rd=-2560; busy=0, done=0, spike_valid=0.
2. Latency, N=4: single step_start -> busy=1 from the next cycle; done=1 only in cycle 21; exactly one done. A second step_start at cycle 3 is ignored (still one done, at 21).
3. Rest stability: zero stimulus, 200 steps -> every v stays within [-4935,-4895]; no spike_valid.
4. Stimulus: write i_data=3277 to index 2 (during busy is allowed), then run 3000 steps -> repeated spike_valid with spike_id=2, at least 3 events; spike_id never 0, 1 or 3.
5. Reset mid-step: rst=0 at cycle 10 of a step -> busy=0, no done, all v=-4915 and all stimulus=0 after release; the next step behaves as in scenario 2.
6. FHN_NOISE_EN defined: zero stimulus, 100 steps -> v[0] differs from its noiseless value, and two runs match bit-exactly. Undefined: matches the scenario 3 reference trace exactly.
